// File: rtl/pll_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_led_pkg
// Description : Shared state encoding for the PLL-driven LED breather.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_led_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    LOCKWAIT  = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_lock_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_qualifier
// Description : Synchronises the asynchronous PLL LOCK into the clk domain and
//               asserts locked once it has been high for LOCK_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_qualifier #(
  parameter int LOCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic pll_lock,
  output logic locked
);

  localparam int c_cnt_w = $clog2(LOCK_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(LOCK_CYCLES);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_lock_cnt;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  // Saturating count of consecutive synchronised-lock-high cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock_cnt <= '0;
    end else if (!r_sync2) begin
      r_lock_cnt <= '0;
    end else if (r_lock_cnt != c_cnt_max) begin
      r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

  // Gating with the synchronised level drops locked in the same cycle the
  // synchronised lock falls, rather than one cycle later when the count clears.
  assign locked = r_sync2 && (r_lock_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/pll_led_breather.sv
`default_nettype none
// ============================================================================
// Module      : pll_led_breather
// Description : Waits for a qualified PLL lock, then drives the LED with a
//               breathing PWM pattern (ramp up, hold, ramp down, hold).
// Revision    : 1.0 - initial release
// ============================================================================
module pll_led_breather
  import pll_led_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 46875,
  parameter int HOLD_STEPS  = 64,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pll_lock,
  input  logic                enable,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [STATE_W-1:0]  state
);

  localparam int c_presc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_hold_w  = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
  localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0]  c_duty_max   = '1;

  state_t                r_state;
  state_t                w_state_nx;
  logic [PWM_BITS-1:0]   r_duty;
  logic [PWM_BITS-1:0]   w_duty_nx;
  logic [c_presc_w-1:0]  r_presc;
  logic [c_presc_w-1:0]  w_presc_nx;
  logic [c_hold_w-1:0]   r_hold;
  logic [c_hold_w-1:0]   w_hold_nx;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic                  r_led;
  logic                  w_locked;
  logic                  w_run;
  logic                  w_tick;

  pll_lock_qualifier #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_qual (
    .clk      (clk),
    .resetn   (resetn),
    .pll_lock (pll_lock),
    .locked   (w_locked)
  );

  assign w_run  = enable && (r_state != LOCKWAIT);
  assign w_tick = w_run && (r_presc == c_presc_last);

  // State, duty, prescaler and hold counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= LOCKWAIT;
      r_duty  <= '0;
      r_presc <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_duty  <= w_duty_nx;
      r_presc <= w_presc_nx;
      r_hold  <= w_hold_nx;
    end
  end

  // Next-state logic: lock loss beats everything, enable=0 freezes, and
  // state/duty/hold only advance on a step tick.
  always_comb begin
    w_state_nx = r_state;
    w_duty_nx  = r_duty;
    w_presc_nx = r_presc;
    w_hold_nx  = r_hold;

    if (r_state == LOCKWAIT) begin
      w_duty_nx  = '0;
      w_presc_nx = '0;
      w_hold_nx  = '0;
      if (w_locked) begin
        w_state_nx = RAMP_UP;
      end
    end else if (!w_locked) begin
      w_state_nx = LOCKWAIT;
      w_duty_nx  = '0;
      w_presc_nx = '0;
      w_hold_nx  = '0;
    end else if (enable) begin
      w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        case (r_state)
          RAMP_UP: begin
            if (r_duty == c_duty_max) begin
              w_state_nx = HOLD_HIGH;
              w_hold_nx  = '0;
            end else begin
              w_duty_nx = r_duty + 1'b1;
            end
          end
          HOLD_HIGH: begin
            if (r_hold == c_hold_last) begin
              w_state_nx = RAMP_DOWN;
              w_hold_nx  = '0;
            end else begin
              w_hold_nx = r_hold + 1'b1;
            end
          end
          RAMP_DOWN: begin
            if (r_duty == '0) begin
              w_state_nx = HOLD_LOW;
              w_hold_nx  = '0;
            end else begin
              w_duty_nx = r_duty - 1'b1;
            end
          end
          HOLD_LOW: begin
            if (r_hold == c_hold_last) begin
              w_state_nx = RAMP_UP;
              w_hold_nx  = '0;
            end else begin
              w_hold_nx = r_hold + 1'b1;
            end
          end
          default: begin
            w_state_nx = LOCKWAIT;
            w_duty_nx  = '0;
            w_presc_nx = '0;
            w_hold_nx  = '0;
          end
        endcase
      end
    end
  end

  // Free-running PWM counter, independent of state and enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Registered PWM compare; one cycle behind the counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led <= 1'b0;
    end else begin
      r_led <= enable && (r_state != LOCKWAIT) && (r_pwm_cnt < r_duty);
    end
  end

  assign led   = r_led;
  assign duty  = r_duty;
  assign state = r_state;

endmodule
`default_nettype wire

// File: doc/pll_led_breather.md
Name: pll_led_breather

Overview:
- Downstream consumer of the iCE40 PLL stage.
- Runs entirely on the PLL output clock (GENCLK) and waits until the PLL LOCK indication has been stable.
- Then drives the board LED with a "breathing" PWM pattern: ramp up, hold, ramp down, hold, repeat.
- Replaces wiring the raw PLL clock to the LED; gives a visible, frequency-dependent indication that the PLL is running at the programmed rate.

Parameters:
- PWM_BITS, 8: width of the PWM counter and of duty; duty range 0..2^PWM_BITS-1.
- PRESCALE, 46875: clk cycles per step tick; must be >= 1.
- HOLD_STEPS, 64: ticks spent in each hold state; must be >= 1.
- LOCK_CYCLES, 1024: consecutive synchronised-lock-high cycles required before leaving LOCKWAIT; must be >= 1.

Ports:
- clk  input  1  PLL output clock (PLLOUTCORE); the block's only clock.
- resetn  input  1  asynchronous, active-low reset.
- pll_lock  input  1  PLL LOCK; asynchronous to clk, synchronised internally.
- enable  input  1  run/freeze control, synchronous to clk.
- led  output  1  registered PWM output.
- duty  output  PWM_BITS  current duty value.
- state  output  3  current FSM state, encoded per package.

Behaviour:
- Clocking and reset:
  - Single clock: clk.
  - Reset is asynchronous and active-low (resetn); the polarity and synchronicity are fixed.
  - Reset values: led=0, duty=0, state=LOCKWAIT. All internal counters and both synchroniser flops are 0.
- Lock qualification:
  - pll_lock passes through a 2-flop synchroniser, giving lock_s.
  - lock_cnt increments while lock_s=1 and saturates at LOCK_CYCLES.
  - lock_cnt clears to 0 on any cycle with lock_s=0.
  - locked = (lock_cnt == LOCK_CYCLES).
- PWM:
  - pwm_cnt is free-running, wraps 2^PWM_BITS-1 -> 0, and runs in every state.
  - led is registered as (enable && state!=LOCKWAIT && pwm_cnt < duty), so led has one cycle of latency.
  - duty=0 gives constantly off; maximum duty gives (2^PWM_BITS-1)/2^PWM_BITS on-time.
- Step tick:
  - presc counts 0..PRESCALE-1 only while enable=1 and state!=LOCKWAIT.
  - tick is asserted for one cycle when presc==PRESCALE-1 (presc wraps to 0 on that cycle).
- FSM (transitions are evaluated on tick unless stated otherwise):
  - LOCKWAIT: duty=0, presc=0, hold=0. Goes to RAMP_UP on the first cycle where locked=1 (no tick needed).
  - RAMP_UP: if duty==MAX, go to HOLD_HIGH with hold=0; else duty+1.
  - HOLD_HIGH: if hold==HOLD_STEPS-1, go to RAMP_DOWN with hold=0; else hold+1.
  - RAMP_DOWN: if duty==0, go to HOLD_LOW with hold=0; else duty-1.
  - HOLD_LOW: if hold==HOLD_STEPS-1, go to RAMP_UP with hold=0; else hold+1.
  - duty never wraps.
  - Breath period = (2*2^PWM_BITS + 2*HOLD_STEPS)*PRESCALE cycles.
- Lock loss:
  - In any non-LOCKWAIT state, locked=0 forces state=LOCKWAIT, duty=0, presc=0, hold=0 on the next edge.
  - Lock loss takes priority over tick and enable.
- enable=0:
  - presc, hold, duty and state are frozen; led=0 on the next edge.
  - Lock qualification continues; lock loss still forces LOCKWAIT.
  - On re-enable the block resumes from the frozen values.
- Reset mid-operation: outputs go to their reset values immediately (asynchronous); after deassertion the block restarts the lock qualification.

Decomposition:
- Package pll_led_pkg holds:
  - state enum: LOCKWAIT=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4 (3 bits);
  - localparam STATE_W=3.
- One sub-module, pll_lock_qualifier: synchroniser plus saturating lock_cnt; output locked.
- FSM, prescaler and PWM stay in the top module.

Test Plan (PWM_BITS=3, PRESCALE=2, HOLD_STEPS=2, LOCK_CYCLES=4 unless noted):
1. Lock acquisition: release reset with pll_lock=1 held before the first edge -> state=RAMP_UP exactly after edge 7; led=0 and duty=0 before that.
2. Breath period: enable=1, lock stable:
   - duty steps 0..7, each held 2 cycles;
   - HOLD_HIGH lasts 4 cycles, then the ramp down mirrors;
   - full period = 40 cycles, repeating identically.
3. PWM fidelity: duty frozen at 5 via enable timing (PRESCALE=1000) -> led high 5 of every 8 cycles, 1 cycle behind pwm_cnt.
4. Lock loss: drop pll_lock during RAMP_DOWN at duty=4 -> state=LOCKWAIT and duty=0 by the 3rd edge; led=0 by the 4th; relock -> RAMP_UP 7 edges later.
5. Freeze: enable=0 for 10 cycles in RAMP_UP at duty=3 -> led=0, duty=3, state=RAMP_UP throughout; resumes with duty=4 after the remaining presc count.
6. Async reset: assert resetn=0 mid-HOLD_HIGH between edges -> led=0, duty=0, state=LOCKWAIT without waiting for an edge.
